// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle sequencer that drives the single-cycle ALU to build
//            variable-amount shifts and an unsigned 32x32 (low-half) multiply.
//            Optional multiply datapath: define ALU_SEQ_MUL_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        illegal_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_ctl_o,
    input  logic [31:0] alu_result_i
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_DONE    = 3'd2;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] ST_MUL_ADD = 3'd3;
    localparam logic [2:0] ST_MUL_SHL = 3'd4;
    localparam logic [3:0] CTL_ADD    = 4'b0010;
`endif
    localparam logic [3:0] CTL_AND    = 4'b0000;
    localparam logic [3:0] CTL_SLL    = 4'b0011;
    localparam logic [3:0] CTL_SRL    = 4'b0100;

    logic [2:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sll_q, sll_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;
`ifdef ALU_SEQ_MUL_EN
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
`else
    // Upper shift-amount bits only matter as the multiplicand.
    logic        unused_src_a;
    assign unused_src_a = ^src_a_i[31:5];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sll_d     = sll_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`endif
        alu_a_o   = 32'd0;
        alu_b_o   = 32'd0;
        alu_ctl_o = CTL_AND;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    illegal_d = 1'b0;
                    case (op_i)
                        2'b00, 2'b01: begin
                            acc_d = src_b_i;
                            cnt_d = {1'b0, src_a_i[4:0]};
                            sll_d = (op_i == 2'b00);
                            if (src_a_i[4:0] == 5'd0) begin
                                result_d = src_b_i;
                                state_d  = ST_DONE;
                            end else begin
                                state_d  = ST_SHIFT;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        2'b10: begin
                            mcand_d  = src_a_i;
                            mplier_d = src_b_i;
                            acc_d    = 32'd0;
                            cnt_d    = 6'd32;
                            state_d  = ST_MUL_ADD;
                        end
`endif
                        default: begin
                            illegal_d = 1'b1;
                            result_d  = 32'd0;
                            state_d   = ST_DONE;
                        end
                    endcase
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                alu_b_o   = acc_q;
                alu_ctl_o = sll_q ? CTL_SLL : CTL_SRL;
                acc_d     = alu_result_i;
                cnt_d     = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    result_d = alu_result_i;
                    state_d  = ST_DONE;
                end
            end

`ifdef ALU_SEQ_MUL_EN
            // A zero multiplier bit still spends its add slot: fixed latency.
            ST_MUL_ADD: begin
                if (mplier_q[0]) begin
                    alu_a_o   = acc_q;
                    alu_b_o   = mcand_q;
                    alu_ctl_o = CTL_ADD;
                    acc_d     = alu_result_i;
                end
                state_d = ST_MUL_SHL;
            end

            ST_MUL_SHL: begin
                alu_b_o   = mcand_q;
                alu_ctl_o = CTL_SLL;
                mcand_d   = alu_result_i;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    result_d = acc_q;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_MUL_ADD;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= 32'd0;
            cnt_q     <= 6'd0;
            sll_q     <= 1'b0;
            result_q  <= 32'd0;
            illegal_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sll_q     <= sll_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`endif
        end
    end

    assign done_o    = (state_q == ST_DONE);
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign result_o  = result_q;
    assign illegal_o = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed-vector bench for alu_seq with a behavioural ALU beside it.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        illegal_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [3:0]  alu_ctl_o;
    logic [31:0] alu_result_i;

    int total = 0;
    int bad   = 0;

    alu_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .op_i         (op_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .illegal_o    (illegal_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_ctl_o    (alu_ctl_o),
        .alu_result_i (alu_result_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle ALU: AND, ADDU, and shift-by-one of port b.
    always_comb begin
        case (alu_ctl_o)
            4'b0000: alu_result_i = alu_a_o & alu_b_o;
            4'b0010: alu_result_i = alu_a_o + alu_b_o;
            4'b0011: alu_result_i = alu_b_o << 1;
            4'b0100: alu_result_i = alu_b_o >> 1;
            default: alu_result_i = 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Issues one op at cycle 0 and waits for done. With noise set, start is
    // pulsed with junk while busy, stopping before the done cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input bit noise,
                          output int cyc, output int busy_low);
        @(negedge clk);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        busy_low = 0;
        while (!done_o && cyc < 200) begin
            if (!busy_o) busy_low++;
            if (noise && cyc < exp_cyc - 1) begin
                start_i = cyc[0];
                op_i    = 2'($urandom_range(0, 3));
                src_a_i = $urandom;
                src_b_i = $urandom;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        if (cyc >= 200) begin
            total++; bad++;
            $display("FAIL %s timeout waiting for done", name);
        end
    endtask

    initial begin
        int cyc, blow;
        logic [31:0] prev;

        vecs[0] = '{2'b00, 32'd31,        32'h00000001, 32'h80000000, 1'b0, 32};
        vecs[1] = '{2'b01, 32'h00000024,  32'h80000000, 32'h08000000, 1'b0, 5};
        vecs[2] = '{2'b00, 32'd0,         32'h12345678, 32'h12345678, 1'b0, 1};
        vecs[3] = '{2'b11, 32'h5,         32'h9,        32'h00000000, 1'b1, 1};
        vecs[4] = '{2'b00, 32'd4,         32'h0000000F, 32'h000000F0, 1'b0, 5};
        vecs[5] = '{2'b01, 32'hFFFFFFE1,  32'hF0000001, 32'h78000000, 1'b0, 2};
`ifdef ALU_SEQ_MUL_EN
        vecs[6] = '{2'b10, 32'd7,         32'd6,        32'h0000002A, 1'b0, 65};
        vecs[7] = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, 1'b0, 65};
        vecs[8] = '{2'b10, 32'h12345678,  32'h00000010, 32'h23456780, 1'b0, 65};
`else
        vecs[6] = '{2'b10, 32'd7,         32'd6,        32'h00000000, 1'b1, 1};
        vecs[7] = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 1'b1, 1};
        vecs[8] = '{2'b10, 32'h12345678,  32'h00000010, 32'h00000000, 1'b1, 1};
`endif
        vecs[9] = '{2'b01, 32'd31,        32'hFFFFFFFF, 32'h00000001, 1'b0, 32};

        rst = 1'b1; start_i = 1'b0; op_i = 2'b00; src_a_i = 32'd0; src_b_i = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",    {31'd0, busy_o},    32'd0);
        check("reset_done",    {31'd0, done_o},    32'd0);
        check("reset_result",  result_o,           32'd0);
        check("reset_illegal", {31'd0, illegal_o}, 32'd0);
        check("reset_alu_ctl", {28'd0, alu_ctl_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].cyc, 1'b0, cyc, blow);
            check($sformatf("vec%0d_cycle", i),   cyc,                    vecs[i].cyc);
            check($sformatf("vec%0d_result", i),  result_o,               vecs[i].res);
            check($sformatf("vec%0d_illegal", i), {31'd0, illegal_o},     {31'd0, vecs[i].ill});
            check($sformatf("vec%0d_busy", i),    blow,                   0);
            check($sformatf("vec%0d_alu_idle", i), alu_a_o | alu_b_o | {28'd0, alu_ctl_o}, 32'd0);
        end

        // Back-to-back: shamt-0 SLL, then SRL by 1 accepted in its done cycle.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd0; src_b_i = 32'h12345678;
        @(negedge clk);
        check("b2b_first_done",   {31'd0, done_o}, 32'd1);
        check("b2b_first_result", result_o,        32'h12345678);
        op_i = 2'b01; src_a_i = 32'd1;
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_shift_busy", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        check("b2b_second_done",   {31'd0, done_o}, 32'd1);
        check("b2b_second_result", result_o,        32'h091A2B3C);

        // start pulses while busy are ignored.
        prev = 32'h0;
`ifdef ALU_SEQ_MUL_EN
        run_op("noise", 2'b10, 32'd7, 32'd6, 65, 1'b1, cyc, blow);
        check("noise_cycle",  cyc,      65);
        check("noise_result", result_o, 32'h0000002A);
`else
        run_op("noise", 2'b00, 32'd31, 32'h00000003, 32, 1'b1, cyc, blow);
        check("noise_cycle",  cyc,      32);
        check("noise_result", result_o, 32'h80000000);
`endif
        check("noise_illegal", {31'd0, illegal_o}, 32'd0);
        check("noise_busy",    blow,               0);

        // Reset in the middle of a long operation aborts without a done pulse.
        @(negedge clk);
        start_i = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        op_i = 2'b10; src_a_i = 32'd3; src_b_i = 32'd5;
`else
        op_i = 2'b00; src_a_i = 32'd31; src_b_i = 32'd1;
`endif
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_busy_before", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",    {31'd0, busy_o},    32'd0);
        check("abort_done",    {31'd0, done_o},    32'd0);
        check("abort_result",  result_o,           32'd0);
        check("abort_alu_ctl", {28'd0, alu_ctl_o}, 32'd0);
        blow = 0;
        for (int k = 0; k < 70; k++) begin
            if (done_o || busy_o) blow++;
            @(negedge clk);
        end
        check("abort_no_done", blow, 0);

        // Illegal op followed by a valid shift clears illegal on acceptance.
        run_op("ill", 2'b11, 32'd0, 32'd0, 1, 1'b0, cyc, blow);
        check("ill_illegal", {31'd0, illegal_o}, 32'd1);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd2; src_b_i = 32'd1;
        @(negedge clk);
        start_i = 1'b0;
        check("ill_cleared", {31'd0, illegal_o}, 32'd0);
        check("ill_result_held", result_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("ill_next_result", result_o, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
